// File: rtl/bit_index_encoder_pkg.sv
// Shared constants, FSM state type and width helper for the bit-index encoder.
package bit_index_encoder_pkg;

  localparam int MODE_ONEHOT = 0;
  localparam int MODE_ENUM   = 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Index width for an N-bit vector; callers guarantee value >= 2.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/bit_index_encoder_if.sv
// Request-vector input channel and index output channel of the bit-index encoder.
interface bit_index_encoder_if
  import bit_index_encoder_pkg::*;
#(
  parameter int N = 8
) ();

  localparam int W = clog2(N);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_vec;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_idx;
  logic         out_last;
  logic         out_err;

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_idx, out_last, out_err
  );

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_idx, out_last, out_err
  );

endinterface

// File: rtl/bit_index_encoder_prio_enc.sv
// Combinational priority encoder: index of the highest-priority set bit plus
// any/multi occupancy flags. idx is 0 when no bit is set.
module prio_enc
  import bit_index_encoder_pkg::*;
#(
  parameter  int N         = 8,
  parameter  int MSB_FIRST = 0,
  localparam int W         = clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any,
  output logic         multi
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    idx = '0;
    // The last hit in scan order wins, so scan towards the priority end.
    if (MSB_FIRST != 0) begin
      for (int i = 0; i < N; i++) begin
        if (vec[i]) idx = W'(i);
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (vec[i]) idx = W'(i);
      end
    end
  end

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign any   = |vec;
  assign multi = |(vec & (vec - N'(1)));

endmodule

// File: rtl/bit_index_encoder.sv
// Handshaked bit-index encoder: one beat per vector (one-hot check) or one beat
// per set bit (enumeration), with zero-bubble back-to-back vector acceptance.
module bit_index_encoder
  import bit_index_encoder_pkg::*;
#(
  parameter int N         = 8,
  parameter int MODE      = MODE_ONEHOT,
  parameter int MSB_FIRST = 0
) (
  input logic                 clk,
  input logic                 rst_n,
  bit_index_encoder_if.slave  bus
);

  localparam int W = clog2(N);

  state_e       state_q, state_d;
  logic [N-1:0] pending_q, pending_d;

  logic [W-1:0] pe_idx;
  logic         pe_any;
  logic         pe_multi;

  logic         out_valid;
  logic         out_last;
  logic         out_err;
  logic         out_hs;
  logic         in_ready;
  logic         accept;
  logic [N-1:0] clear_mask;

  prio_enc #(
    .N         (N),
    .MSB_FIRST (MSB_FIRST)
  ) u_prio_enc (
    .vec   (pending_q),
    .idx   (pe_idx),
    .any   (pe_any),
    .multi (pe_multi)
  );

  // Outputs are gated by rst_n so nothing is presented while reset is asserted.
  always_comb begin
    out_valid = rst_n && (state_q == BUSY);
    out_last  = 1'b0;
    out_err   = 1'b0;
    if (out_valid) begin
      if (MODE == MODE_ENUM) begin
        out_last = !pe_multi;
        out_err  = !pe_any;
      end else begin
        out_last = 1'b1;
        out_err  = !pe_any || pe_multi;
      end
    end
  end

  // in_ready depends combinationally on out_ready to allow a new vector on the last beat.
  assign out_hs     = out_valid && bus.out_ready;
  assign in_ready   = rst_n && ((state_q == IDLE) || (out_hs && out_last));
  assign accept     = bus.in_valid && in_ready;
  assign clear_mask = N'(1) << pe_idx;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    if (out_hs) begin
      pending_d = pending_q & ~clear_mask;
      if (out_last) state_d = IDLE;
    end
    // A vector accepted on the final handshake overrides the return to IDLE.
    if (accept) begin
      state_d   = BUSY;
      pending_d = bus.in_vec;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_idx   = out_valid ? pe_idx : '0;
  assign bus.out_last  = out_last;
  assign bus.out_err   = out_err;

endmodule

// File: tb/tb_bit_index_encoder.sv
// Directed self-checking bench for bit_index_encoder: one-hot, LSB/MSB enumeration,
// stalls, back-to-back vectors, mid-vector reset and a 16-bit instance.
module tb_bit_index_encoder;
  import bit_index_encoder_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  bit_index_encoder_if #(.N(8))  b_oh  ();
  bit_index_encoder_if #(.N(8))  b_lsb ();
  bit_index_encoder_if #(.N(8))  b_msb ();
  bit_index_encoder_if #(.N(16)) b_16  ();

  bit_index_encoder #(.N(8), .MODE(MODE_ONEHOT), .MSB_FIRST(0)) u_oh (
    .clk(clk), .rst_n(rst_n), .bus(b_oh));
  bit_index_encoder #(.N(8), .MODE(MODE_ENUM), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .bus(b_lsb));
  bit_index_encoder #(.N(8), .MODE(MODE_ENUM), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst_n(rst_n), .bus(b_msb));
  bit_index_encoder #(.N(16), .MODE(MODE_ENUM), .MSB_FIRST(0)) u_16 (
    .clk(clk), .rst_n(rst_n), .bus(b_16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    b_oh.in_valid  = 1'b0; b_oh.in_vec  = '0; b_oh.out_ready  = 1'b0;
    b_lsb.in_valid = 1'b0; b_lsb.in_vec = '0; b_lsb.out_ready = 1'b0;
    b_msb.in_valid = 1'b0; b_msb.in_vec = '0; b_msb.out_ready = 1'b0;
    b_16.in_valid  = 1'b0; b_16.in_vec  = '0; b_16.out_ready  = 1'b0;
    tick();
    tick();
    checks++;
    if (b_oh.in_ready !== 1'b0 || b_lsb.in_ready !== 1'b0 || b_16.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready: got %b%b%b expected 000", b_oh.in_ready, b_lsb.in_ready, b_16.in_ready);
    end
    checks++;
    if (b_oh.out_valid !== 1'b0 || b_msb.out_valid !== 1'b0 || b_oh.out_idx !== 3'd0 ||
        b_oh.out_last !== 1'b0 || b_oh.out_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b idx=%0d last=%b err=%b expected 0 0 0 0",
               b_oh.out_valid, b_oh.out_idx, b_oh.out_last, b_oh.out_err);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (b_oh.in_ready !== 1'b1 || b_lsb.in_ready !== 1'b1 || b_msb.in_ready !== 1'b1 ||
        b_16.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_in_ready: got %b%b%b%b expected 1111",
               b_oh.in_ready, b_lsb.in_ready, b_msb.in_ready, b_16.in_ready);
    end
  endtask

  task automatic test_onehot();
    logic [7:0] vecs     [3] = '{8'h10, 8'h24, 8'h00};
    logic [2:0] exp_idx  [3] = '{3'd4, 3'd2, 3'd0};
    logic       exp_err  [3] = '{1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 3; k++) begin
      b_oh.in_valid  = 1'b1;
      b_oh.in_vec    = vecs[k];
      b_oh.out_ready = 1'b1;
      #1;
      checks++;
      if (b_oh.out_valid !== 1'b0 || b_oh.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL onehot_idle[%0d]: got valid=%b in_ready=%b expected 0 1", k, b_oh.out_valid, b_oh.in_ready);
      end
      tick();
      b_oh.in_valid = 1'b0;
      b_oh.in_vec   = 8'hFF;
      #1;
      checks++;
      if (b_oh.out_valid !== 1'b1 || b_oh.out_idx !== exp_idx[k] || b_oh.out_last !== 1'b1 ||
          b_oh.out_err !== exp_err[k]) begin
        errors++;
        $display("FAIL onehot_beat[%0d]: got valid=%b idx=%0d last=%b err=%b expected 1 %0d 1 %b",
                 k, b_oh.out_valid, b_oh.out_idx, b_oh.out_last, b_oh.out_err, exp_idx[k], exp_err[k]);
      end
      tick();
    end
    #1;
    checks++;
    if (b_oh.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL onehot_done: got valid=%b expected 0", b_oh.out_valid);
    end
  endtask

  task automatic test_enum_order();
    logic [2:0] exp_l [4] = '{3'd1, 3'd2, 3'd5, 3'd7};
    logic [2:0] exp_m [4] = '{3'd7, 3'd5, 3'd2, 3'd1};
    b_lsb.in_valid = 1'b1; b_lsb.in_vec = 8'b1010_0110; b_lsb.out_ready = 1'b1;
    b_msb.in_valid = 1'b1; b_msb.in_vec = 8'b1010_0110; b_msb.out_ready = 1'b1;
    #1;
    tick();
    b_lsb.in_valid = 1'b0;
    b_msb.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (b_lsb.out_valid !== 1'b1 || b_lsb.out_idx !== exp_l[k] || b_lsb.out_last !== (k == 3) ||
          b_lsb.out_err !== 1'b0 || b_lsb.in_ready !== (k == 3)) begin
        errors++;
        $display("FAIL enum_lsb[%0d]: got valid=%b idx=%0d last=%b err=%b in_ready=%b expected 1 %0d %b 0 %b",
                 k, b_lsb.out_valid, b_lsb.out_idx, b_lsb.out_last, b_lsb.out_err, b_lsb.in_ready,
                 exp_l[k], (k == 3), (k == 3));
      end
      checks++;
      if (b_msb.out_valid !== 1'b1 || b_msb.out_idx !== exp_m[k] || b_msb.out_last !== (k == 3)) begin
        errors++;
        $display("FAIL enum_msb[%0d]: got valid=%b idx=%0d last=%b expected 1 %0d %b",
                 k, b_msb.out_valid, b_msb.out_idx, b_msb.out_last, exp_m[k], (k == 3));
      end
      tick();
    end
    #1;
    checks++;
    if (b_lsb.out_valid !== 1'b0 || b_msb.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL enum_order_done: got valid=%b%b expected 00", b_lsb.out_valid, b_msb.out_valid);
    end
  endtask

  task automatic test_stall();
    int beat;
    int cyc;
    b_lsb.in_valid = 1'b1; b_lsb.in_vec = 8'hFF; b_lsb.out_ready = 1'b1;
    #1;
    tick();
    b_lsb.in_valid = 1'b0;
    beat = 0;
    cyc  = 0;
    while (beat < 8 && cyc < 40) begin
      b_lsb.out_ready = (cyc % 2 == 0);
      #1;
      checks++;
      if (b_lsb.out_valid !== 1'b1 || b_lsb.out_idx !== 3'(beat) || b_lsb.out_last !== (beat == 7) ||
          b_lsb.in_ready !== (beat == 7 && b_lsb.out_ready)) begin
        errors++;
        $display("FAIL stall_beat[cyc %0d]: got valid=%b idx=%0d last=%b in_ready=%b expected 1 %0d %b %b",
                 cyc, b_lsb.out_valid, b_lsb.out_idx, b_lsb.out_last, b_lsb.in_ready,
                 beat, (beat == 7), (beat == 7 && b_lsb.out_ready));
      end
      if (b_lsb.out_ready) beat++;
      cyc++;
      tick();
    end
    checks++;
    if (beat != 8) begin
      errors++;
      $display("FAIL stall_timeout: got %0d beats expected 8", beat);
    end
    b_lsb.out_ready = 1'b1;
    #1;
    checks++;
    if (b_lsb.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_done: got valid=%b expected 0", b_lsb.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    b_lsb.in_valid = 1'b1; b_lsb.in_vec = 8'h03; b_lsb.out_ready = 1'b1;
    #1;
    tick();
    b_lsb.in_vec = 8'h80;
    #1;
    checks++;
    if (b_lsb.out_valid !== 1'b1 || b_lsb.out_idx !== 3'd0 || b_lsb.out_last !== 1'b0 ||
        b_lsb.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_beat0: got valid=%b idx=%0d last=%b in_ready=%b expected 1 0 0 0",
               b_lsb.out_valid, b_lsb.out_idx, b_lsb.out_last, b_lsb.in_ready);
    end
    tick();
    #1;
    checks++;
    if (b_lsb.out_valid !== 1'b1 || b_lsb.out_idx !== 3'd1 || b_lsb.out_last !== 1'b1 ||
        b_lsb.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_beat1: got valid=%b idx=%0d last=%b in_ready=%b expected 1 1 1 1",
               b_lsb.out_valid, b_lsb.out_idx, b_lsb.out_last, b_lsb.in_ready);
    end
    tick();
    b_lsb.in_valid = 1'b0;
    #1;
    checks++;
    if (b_lsb.out_valid !== 1'b1 || b_lsb.out_idx !== 3'd7 || b_lsb.out_last !== 1'b1) begin
      errors++;
      $display("FAIL b2b_beat7: got valid=%b idx=%0d last=%b expected 1 7 1",
               b_lsb.out_valid, b_lsb.out_idx, b_lsb.out_last);
    end
    tick();
    #1;
    checks++;
    if (b_lsb.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done: got valid=%b expected 0", b_lsb.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    b_lsb.in_valid = 1'b1; b_lsb.in_vec = 8'hF0; b_lsb.out_ready = 1'b1;
    #1;
    tick();
    b_lsb.in_valid = 1'b0;
    #1;
    checks++;
    if (b_lsb.out_valid !== 1'b1 || b_lsb.out_idx !== 3'd4) begin
      errors++;
      $display("FAIL rstmid_beat4: got valid=%b idx=%0d expected 1 4", b_lsb.out_valid, b_lsb.out_idx);
    end
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (b_lsb.out_valid !== 1'b0 || b_lsb.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_asserted: got valid=%b in_ready=%b expected 0 0", b_lsb.out_valid, b_lsb.in_ready);
    end
    tick();
    checks++;
    if (b_lsb.out_valid !== 1'b0 || b_lsb.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_held: got valid=%b in_ready=%b expected 0 0", b_lsb.out_valid, b_lsb.in_ready);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (b_lsb.out_valid !== 1'b0 || b_lsb.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_release: got valid=%b in_ready=%b expected 0 1", b_lsb.out_valid, b_lsb.in_ready);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (b_lsb.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_no_beat[%0d]: got valid=%b idx=%0d expected valid 0", k, b_lsb.out_valid, b_lsb.out_idx);
      end
    end
  endtask

  task automatic test_wide();
    b_16.in_valid = 1'b1; b_16.in_vec = 16'h8001; b_16.out_ready = 1'b1;
    #1;
    tick();
    b_16.in_valid = 1'b0;
    #1;
    checks++;
    if (b_16.out_valid !== 1'b1 || b_16.out_idx !== 4'd0 || b_16.out_last !== 1'b0 || b_16.out_err !== 1'b0) begin
      errors++;
      $display("FAIL wide_beat0: got valid=%b idx=%0d last=%b err=%b expected 1 0 0 0",
               b_16.out_valid, b_16.out_idx, b_16.out_last, b_16.out_err);
    end
    tick();
    checks++;
    if (b_16.out_valid !== 1'b1 || b_16.out_idx !== 4'd15 || b_16.out_last !== 1'b1) begin
      errors++;
      $display("FAIL wide_beat15: got valid=%b idx=%0d last=%b expected 1 15 1",
               b_16.out_valid, b_16.out_idx, b_16.out_last);
    end
    b_16.in_valid = 1'b1;
    b_16.in_vec   = 16'h0000;
    #1;
    tick();
    b_16.in_valid = 1'b0;
    #1;
    checks++;
    if (b_16.out_valid !== 1'b1 || b_16.out_idx !== 4'd0 || b_16.out_last !== 1'b1 || b_16.out_err !== 1'b1) begin
      errors++;
      $display("FAIL wide_zero: got valid=%b idx=%0d last=%b err=%b expected 1 0 1 1",
               b_16.out_valid, b_16.out_idx, b_16.out_last, b_16.out_err);
    end
    tick();
    checks++;
    if (b_16.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL wide_zero_single: got valid=%b expected 0", b_16.out_valid);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_onehot();
    test_enum_order();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
